reaction_controller: RTL and testbench
======================================

Name: reaction_controller

Overview:
- Game-control stage for the reaction-timer design, driving and consuming the countdown_timer.
- On a start pulse it resets and enables the countdown timer, then waits for end_reached.
- When end_reached arrives it lights the GO LED and measures the player's reaction in milliseconds.
- Reports the result, a false start (button pressed before GO), or a timeout.

Parameters:
- CLKS_PER_MS, 50000: clock cycles per millisecond (50 MHz clock).
- MAX_MS, 3000: countdown_timer start value; sets the timer_value width, $clog2(MAX_MS).
- MAX_REACT_MS, 2000: reaction window; reaching this count is a timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse from the debounced start key.
- button  in  1  single-cycle pulse from the debounced reaction key.
- timer_value  in  $clog2(MAX_MS)  remaining ms from countdown_timer (passed through for display only).
- end_reached  in  1  countdown_timer has reached zero.
- timer_reset  out  1  active-high one-cycle reset pulse to countdown_timer.
- timer_enable  out  1  countdown_timer enable.
- go_led  out  1  GO indicator.
- reaction_ms  out  $clog2(MAX_REACT_MS+1)  measured reaction time.
- result_valid  out  1  reaction_ms holds a valid result.
- false_start  out  1  button was pressed before GO.
- timeout  out  1  no button press within MAX_REACT_MS.
- display_ms  out  $clog2(MAX_MS)  timer_value while in WAIT, otherwise zero-extended reaction_ms.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; prescaler=0.
  - All outputs 0; reaction_ms=0.
- States: IDLE, ARM, WAIT, GO, RESULT, FAIL.
- IDLE/RESULT/FAIL + start:
  - Next cycle ARM.
  - Clear result_valid, false_start, timeout and reaction_ms in that same transition.
- ARM:
  - timer_reset=1 for exactly one cycle.
  - Unconditionally go to WAIT the next cycle.
- WAIT:
  - timer_enable=1 (registered, high from the first WAIT cycle).
  - button → FAIL with false_start=1 and timer_enable=0.
  - Else end_reached → GO.
  - button and end_reached in the same cycle: button wins (FAIL).
- GO, entry:
  - go_led=1 and timer_enable=0.
  - Prescaler and reaction_ms start from 0 on the first GO cycle.
- GO, ms counting:
  - Prescaler counts 0..CLKS_PER_MS-1 and wraps.
  - The wrap cycle is the ms tick; reaction_ms increments on each tick.
- GO, exits:
  - button → RESULT: reaction_ms frozen, result_valid=1, go_led=0.
  - button in the same cycle as a tick: button wins, and the tick increment is discarded.
  - A tick that would make reaction_ms == MAX_REACT_MS → FAIL: reaction_ms=MAX_REACT_MS (saturated), timeout=1, go_led=0.
- RESULT/FAIL:
  - Outputs held until the next start.
  - button is ignored.
- start is ignored in ARM, WAIT and GO (no abort).
- All outputs are registered; state-change latency is 1 cycle from the input pulse.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No pending timer_reset pulse is emitted.

Decomposition:
- reaction_pkg holds:
  - the state_t enum (3-bit, encodings IDLE=0, ARM=1, WAIT=2, GO=3, RESULT=4, FAIL=5);
  - width helper constants derived from MAX_MS and MAX_REACT_MS.
- One sub-module: ms_tick_gen, the CLKS_PER_MS prescaler.
  - Ports: clk, reset, clear, tick.
  - clear zeroes the count synchronously; tick is high on the wrap cycle.
- The FSM and the result registers stay in reaction_controller.

Test Plan (CLKS_PER_MS=4, MAX_MS=8, MAX_REACT_MS=10 for sim):
- Reset held low mid-GO → all outputs 0 and state IDLE asynchronously, before the next clk edge; after release, idle until start.
- Start pulse → timer_reset high exactly 1 cycle, then timer_enable=1; drive end_reached after 32 clks → go_led=1 the next cycle.
- In GO, button after 5 ticks (20 clks) → result_valid=1, reaction_ms=5, go_led=0; value held through 100 clks and ignores further button pulses.
- Button during WAIT → false_start=1, timer_enable=0, result_valid=0.
- Button and end_reached in the same cycle → false_start=1, go_led stays 0.
- No button in GO → after 40 clks timeout=1, reaction_ms=10; the next start clears all flags and the round repeats.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and width helpers for the reaction-timer game controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        WAIT   = 3'd2,
        GO     = 3'd3,
        RESULT = 3'd4,
        FAIL   = 3'd5
    } state_t;

    localparam int unsigned DEF_CLKS_PER_MS  = 50000;
    localparam int unsigned DEF_MAX_MS       = 3000;
    localparam int unsigned DEF_MAX_REACT_MS = 2000;

    function automatic int unsigned timer_w(input int unsigned max_ms);
        return (max_ms > 1) ? $clog2(max_ms) : 1;
    endfunction

    function automatic int unsigned react_w(input int unsigned max_react);
        return $clog2(max_react + 1);
    endfunction

    function automatic int unsigned presc_w(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

    localparam int unsigned DEF_TIMER_W = timer_w(DEF_MAX_MS);
    localparam int unsigned DEF_REACT_W = react_w(DEF_MAX_REACT_MS);

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLKS_PER_MS-1, tick on the wrap cycle.
module ms_tick_gen
    import reaction_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS = DEF_CLKS_PER_MS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = presc_w(CLKS_PER_MS);

    logic [CW-1:0] count;

    assign tick = (count == CW'(CLKS_PER_MS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/reaction_controller.sv
// Reaction-timer game FSM: arms the countdown, lights GO, measures reaction.
module reaction_controller
    import reaction_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS  = DEF_CLKS_PER_MS,
    parameter int unsigned MAX_MS       = DEF_MAX_MS,
    parameter int unsigned MAX_REACT_MS = DEF_MAX_REACT_MS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               button,
    input  logic [timer_w(MAX_MS)-1:0]         timer_value,
    input  logic                               end_reached,
    output logic                               timer_reset,
    output logic                               timer_enable,
    output logic                               go_led,
    output logic [react_w(MAX_REACT_MS)-1:0]   reaction_ms,
    output logic                               result_valid,
    output logic                               false_start,
    output logic                               timeout,
    output logic [timer_w(MAX_MS)-1:0]         display_ms
);

    localparam int unsigned TW = timer_w(MAX_MS);
    localparam int unsigned RW = react_w(MAX_REACT_MS);

    state_t        state, state_n;
    logic          tick;
    logic          tr_n, te_n, go_n, valid_n, fs_n, to_n;
    logic [RW-1:0] react_n;
    logic [TW-1:0] disp_n;

    // Prescaler sits at zero outside GO so the first GO cycle counts from 0
    ms_tick_gen #(
        .CLKS_PER_MS(CLKS_PER_MS)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(state != GO),
        .tick (tick)
    );

    always_comb begin
        state_n = state;
        tr_n    = 1'b0;
        te_n    = 1'b0;
        go_n    = 1'b0;
        react_n = reaction_ms;
        valid_n = result_valid;
        fs_n    = false_start;
        to_n    = timeout;
        unique case (state)
            IDLE, RESULT, FAIL: begin
                if (start) begin
                    state_n = ARM;
                    tr_n    = 1'b1;
                    react_n = '0;
                    valid_n = 1'b0;
                    fs_n    = 1'b0;
                    to_n    = 1'b0;
                end
            end
            ARM: begin
                state_n = WAIT;
                te_n    = 1'b1;
            end
            WAIT: begin
                te_n = 1'b1;
                if (button) begin
                    state_n = FAIL;
                    fs_n    = 1'b1;
                    te_n    = 1'b0;
                end else if (end_reached) begin
                    state_n = GO;
                    te_n    = 1'b0;
                    go_n    = 1'b1;
                    react_n = '0;
                end
            end
            GO: begin
                go_n = 1'b1;
                // A press on a tick cycle wins and drops that tick
                if (button) begin
                    state_n = RESULT;
                    valid_n = 1'b1;
                    go_n    = 1'b0;
                end else if (tick) begin
                    if (reaction_ms == RW'(MAX_REACT_MS - 1)) begin
                        state_n = FAIL;
                        react_n = RW'(MAX_REACT_MS);
                        to_n    = 1'b1;
                        go_n    = 1'b0;
                    end else begin
                        react_n = reaction_ms + RW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        disp_n = (state_n == WAIT) ? timer_value : TW'(react_n);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            timer_reset  <= 1'b0;
            timer_enable <= 1'b0;
            go_led       <= 1'b0;
            reaction_ms  <= '0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            display_ms   <= '0;
        end else begin
            state        <= state_n;
            timer_reset  <= tr_n;
            timer_enable <= te_n;
            go_led       <= go_n;
            reaction_ms  <= react_n;
            result_valid <= valid_n;
            false_start  <= fs_n;
            timeout      <= to_n;
            display_ms   <= disp_n;
        end
    end

endmodule

// File: tb/tb_reaction_controller.sv
// Directed-vector bench for reaction_controller with small sim parameters.
module tb_reaction_controller;

    localparam int unsigned CPM = 4;
    localparam int unsigned MMS = 8;
    localparam int unsigned MRM = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       button = 1'b0;
    logic [2:0] timer_value = 3'd0;
    logic       end_reached = 1'b0;
    logic       timer_reset;
    logic       timer_enable;
    logic       go_led;
    logic [3:0] reaction_ms;
    logic       result_valid;
    logic       false_start;
    logic       timeout;
    logic [2:0] display_ms;

    int total = 0;
    int bad = 0;

    reaction_controller #(
        .CLKS_PER_MS (CPM),
        .MAX_MS      (MMS),
        .MAX_REACT_MS(MRM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .button      (button),
        .timer_value (timer_value),
        .end_reached (end_reached),
        .timer_reset (timer_reset),
        .timer_enable(timer_enable),
        .go_led      (go_led),
        .reaction_ms (reaction_ms),
        .result_valid(result_valid),
        .false_start (false_start),
        .timeout     (timeout),
        .display_ms  (display_ms)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".tr"}, int'(timer_reset), 0);
        chk({tag, ".te"}, int'(timer_enable), 0);
        chk({tag, ".go"}, int'(go_led), 0);
        chk({tag, ".ms"}, int'(reaction_ms), 0);
        chk({tag, ".rv"}, int'(result_valid), 0);
        chk({tag, ".fs"}, int'(false_start), 0);
        chk({tag, ".to"}, int'(timeout), 0);
        chk({tag, ".disp"}, int'(display_ms), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_button();
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
    endtask

    // start pulse, ARM cycle, then land on the first WAIT cycle
    task automatic to_wait();
        pulse_start();
        @(negedge clk);
    endtask

    task automatic to_go();
        to_wait();
        end_reached = 1'b1;
        @(negedge clk);
        end_reached = 1'b0;
    endtask

    initial begin
        #1;
        chk_zero("rst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("idle");

        // Round 1: normal reaction of 5 ms
        timer_value = 3'd3;
        pulse_start();
        chk("arm.tr", int'(timer_reset), 1);
        chk("arm.te", int'(timer_enable), 0);
        @(negedge clk);
        chk("wait.tr", int'(timer_reset), 0);
        chk("wait.te", int'(timer_enable), 1);
        chk("wait.disp", int'(display_ms), 3);
        repeat (31) @(negedge clk);
        chk("wait32.te", int'(timer_enable), 1);
        chk("wait32.go", int'(go_led), 0);
        end_reached = 1'b1;
        @(negedge clk);
        end_reached = 1'b0;
        chk("go.led", int'(go_led), 1);
        chk("go.te", int'(timer_enable), 0);
        chk("go.ms0", int'(reaction_ms), 0);
        repeat (20) @(negedge clk);
        chk("go20.ms", int'(reaction_ms), 5);
        pulse_button();
        chk("res.rv", int'(result_valid), 1);
        chk("res.ms", int'(reaction_ms), 5);
        chk("res.go", int'(go_led), 0);
        chk("res.disp", int'(display_ms), 5);
        for (int i = 0; i < 10; i++) begin
            repeat (9) @(negedge clk);
            pulse_button();
        end
        chk("hold.rv", int'(result_valid), 1);
        chk("hold.ms", int'(reaction_ms), 5);
        chk("hold.go", int'(go_led), 0);

        // Round 2: false start during WAIT
        pulse_start();
        chk("r2.rv_clr", int'(result_valid), 0);
        chk("r2.ms_clr", int'(reaction_ms), 0);
        @(negedge clk);
        pulse_button();
        chk("r2.fs", int'(false_start), 1);
        chk("r2.te", int'(timer_enable), 0);
        chk("r2.rv", int'(result_valid), 0);

        // Round 3: button and end_reached together
        to_wait();
        chk("r3.fs_clr", int'(false_start), 0);
        button = 1'b1;
        end_reached = 1'b1;
        @(negedge clk);
        button = 1'b0;
        end_reached = 1'b0;
        chk("r3.fs", int'(false_start), 1);
        chk("r3.go", int'(go_led), 0);
        @(negedge clk);
        chk("r3.go2", int'(go_led), 0);

        // Round 4: timeout at MAX_REACT_MS
        to_go();
        chk("r4.go", int'(go_led), 1);
        chk("r4.fs_clr", int'(false_start), 0);
        repeat (39) @(negedge clk);
        chk("r4.to39", int'(timeout), 0);
        chk("r4.ms39", int'(reaction_ms), 9);
        chk("r4.go39", int'(go_led), 1);
        @(negedge clk);
        chk("r4.to", int'(timeout), 1);
        chk("r4.ms", int'(reaction_ms), 10);
        chk("r4.go40", int'(go_led), 0);
        chk("r4.rv", int'(result_valid), 0);
        repeat (5) @(negedge clk);
        chk("r4.hold", int'(reaction_ms), 10);

        // Round 5: restart clears flags; press on a tick cycle drops the tick
        pulse_start();
        chk("r5.to_clr", int'(timeout), 0);
        chk("r5.ms_clr", int'(reaction_ms), 0);
        @(negedge clk);
        end_reached = 1'b1;
        @(negedge clk);
        end_reached = 1'b0;
        repeat (7) @(negedge clk);
        chk("r5.ms7", int'(reaction_ms), 1);
        pulse_button();
        chk("r5.ms", int'(reaction_ms), 1);
        chk("r5.rv", int'(result_valid), 1);

        // Round 6: async reset mid-GO
        to_go();
        repeat (6) @(negedge clk);
        chk("r6.go", int'(go_led), 1);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("r6.async");
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk_zero("r6.idle");
        pulse_start();
        chk("r6.tr", int'(timer_reset), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
